// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the MCU core: word sizes, opcode encodings, the idle word
// and the sequencer state encoding.
package instr_sequencer_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 4;
  localparam int SLP_W   = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_SLP = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SLEEP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle of program-load, control, decoder-feedback and status signals around the
// sequencer. The slave side is the sequencer; the master side is its environment.
interface instr_sequencer_if #(
  parameter int INSTR_W = instr_sequencer_pkg::INSTR_W,
  parameter int ADDR_W  = instr_sequencer_pkg::ADDR_W,
  parameter int SLP_W   = instr_sequencer_pkg::SLP_W
);

  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [ADDR_W:0]    prog_len;
  logic               start;
  logic               stop;
  logic               tick;
  logic               is_jmp;
  logic               is_slp;
  logic [ADDR_W-1:0]  jmp_target;
  logic [SLP_W-1:0]   slp_count;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               sleeping;
  logic               running;

  modport master (
    output load_en, load_addr, load_data, prog_len, start, stop, tick,
           is_jmp, is_slp, jmp_target, slp_count,
    input  instr, instr_valid, pc, sleeping, running
  );

  modport slave (
    input  load_en, load_addr, load_data, prog_len, start, stop, tick,
           is_jmp, is_slp, jmp_target, slp_count,
    output instr, instr_valid, pc, sleeping, running
  );

endinterface

// File: rtl/instr_sequencer_slp_timer.sv
// Sleep-duration down-counter. Loaded with the sleep length, it counts ticks only
// while enabled and flags the tick that ends the sleep.
module instr_sequencer_slp_timer #(
  parameter int SLP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [SLP_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_tick,
  input  logic             i_clear,
  output logic             o_done
);

  logic [SLP_W-1:0] r_count;

  // Load beats tick, so a tick coinciding with the slp instruction is not counted.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = i_en && i_tick && (r_count == SLP_W'(1));

endmodule

// File: rtl/instr_sequencer.sv
// Program memory, PC and IDLE/RUN/SLEEP sequencing feeding the instruction decoder.
// Execution loops back to line 0 after the last loaded line.
module instr_sequencer #(
  parameter int INSTR_W = instr_sequencer_pkg::INSTR_W,
  parameter int ADDR_W  = instr_sequencer_pkg::ADDR_W,
  parameter int SLP_W   = instr_sequencer_pkg::SLP_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = instr_sequencer_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);

  import instr_sequencer_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  seq_state_e         r_state;
  seq_state_e         w_next_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_next_pc;
  logic [ADDR_W:0]    r_len;
  logic [ADDR_W:0]    w_next_len;
  logic [ADDR_W-1:0]  w_seq_pc;
  logic               w_len_ok;
  logic               w_jmp_ok;
  logic               w_tmr_load;
  logic               w_tmr_clear;
  logic               w_tmr_done;
  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Program memory is deliberately not reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (bus.load_en && (r_state == IDLE)) begin
      r_mem[bus.load_addr] <= bus.load_data;
    end
  end

  assign w_seq_pc = ({1'b0, r_pc} == (r_len - 1'b1)) ? '0 : r_pc + 1'b1;
  assign w_len_ok = (bus.prog_len != '0) && (bus.prog_len <= MAX_LEN);
  assign w_jmp_ok = ({1'b0, bus.jmp_target} < r_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_len   <= w_next_len;
    end
  end

  // Per-cycle priority in RUN: stop, then jump, then sleep, then sequential advance.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_len   = r_len;
    w_tmr_load   = 1'b0;
    w_tmr_clear  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.stop && bus.start && w_len_ok) begin
          w_next_state = RUN;
          w_next_pc    = '0;
          w_next_len   = bus.prog_len;
        end
      end
      RUN: begin
        if (bus.stop) begin
          w_next_state = IDLE;
          w_next_pc    = '0;
        end else if (bus.is_jmp) begin
          w_next_pc = w_jmp_ok ? bus.jmp_target : '0;
        end else if (bus.is_slp && (bus.slp_count != '0)) begin
          w_next_pc    = w_seq_pc;
          w_tmr_load   = 1'b1;
          w_next_state = SLEEP;
        end else begin
          w_next_pc = w_seq_pc;
        end
      end
      SLEEP: begin
        if (bus.stop) begin
          w_next_state = IDLE;
          w_next_pc    = '0;
          w_tmr_clear  = 1'b1;
        end else if (w_tmr_done) begin
          w_next_state = RUN;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_pc    = '0;
      end
    endcase
  end

  instr_sequencer_slp_timer #(
    .SLP_W (SLP_W)
  ) u_slp_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (bus.slp_count),
    .i_en       (r_state == SLEEP),
    .i_tick     (bus.tick),
    .i_clear    (w_tmr_clear),
    .o_done     (w_tmr_done)
  );

  assign bus.instr       = (r_state == RUN) ? r_mem[r_pc] : NOP_WORD;
  assign bus.instr_valid = (r_state == RUN);
  assign bus.pc          = r_pc;
  assign bus.sleeping    = (r_state == SLEEP);
  assign bus.running     = (r_state == RUN) || (r_state == SLEEP);

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program-fetch and sequencing unit that feeds the instruction decoder: holds program memory, drives the current instruction word, and reacts to the decoder's is_jmp and is_slp flags.
- Sits upstream of the decoder in the microcontroller core. It owns the PC, the sleep timer and the program-load port.
- Programs loop forever: past the last loaded line, execution wraps to line 0, matching Shenzhen-style MCU semantics.

Parameters:
- INSTR_W, 32, instruction word width
- ADDR_W, 4, PC / program-memory address width (depth 2**ADDR_W)
- SLP_W, 8, sleep-duration width in time units
- NOP_WORD, 32'h0, word driven on instr when no instruction is valid

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_en  in  1  write one program line (honoured only in IDLE)
- load_addr  in  ADDR_W  program line to write
- load_data  in  INSTR_W  program word
- prog_len  in  ADDR_W+1  number of valid lines; sampled on start
- start  in  1  begin execution at line 0
- stop  in  1  abort execution, return to IDLE
- tick  in  1  one-cycle time-unit pulse (sleep timebase)
- is_jmp  in  1  from decoder, same cycle as instr
- is_slp  in  1  from decoder, same cycle as instr
- jmp_target  in  ADDR_W  jump destination from datapath/immediate
- slp_count  in  SLP_W  sleep duration from datapath/immediate
- instr  out  INSTR_W  current instruction to decoder
- instr_valid  out  1  instr is an executing instruction this cycle
- pc  out  ADDR_W  current program counter
- sleeping  out  1  high while in SLEEP
- running  out  1  high in RUN or SLEEP

Behaviour:
- States: IDLE, RUN, SLEEP. Reset → IDLE, pc=0, len_q=0, slp_cnt=0. Memory contents are not cleared.
- Reset outputs: instr=NOP_WORD, instr_valid=0, pc=0, sleeping=0, running=0.
- Memory: 2**ADDR_W × INSTR_W regs. Written on clk when load_en && state==IDLE. Loads in RUN/SLEEP are ignored.
- instr = mem[pc] combinationally when state==RUN; otherwise NOP_WORD. instr_valid = (state==RUN).
- IDLE→RUN on start, only if prog_len!=0 and prog_len<=2**ADDR_W. Latch len_q=prog_len, pc=0. An illegal prog_len leaves the block in IDLE. First instruction is visible the cycle after start.
- RUN, each cycle, priority stop > is_jmp > is_slp > sequential:
  - stop: → IDLE, pc=0.
  - is_jmp: pc ← jmp_target if jmp_target < len_q, else 0.
  - is_slp with slp_count==0: behaves as sequential advance (no sleep).
  - is_slp with slp_count>0: pc ← next_seq; slp_cnt ← slp_count; → SLEEP.
  - sequential: pc ← next_seq, where next_seq = (pc==len_q-1) ? 0 : pc+1.
- SLEEP:
  - On tick: slp_cnt decrements. When tick && slp_cnt==1 → RUN; the next instruction is issued the following cycle.
  - stop → IDLE with slp_cnt cleared. is_jmp/is_slp are ignored (instr_valid=0).
- A tick arriving in the same cycle as the slp instruction does not count toward the sleep.
- is_jmp and is_slp both high: jmp wins, no sleep.
- start while already RUN/SLEEP: ignored. start and stop together in IDLE: stop wins, stays IDLE.
- reset mid-SLEEP or mid-RUN: immediate return to reset state; the program stays loaded.

Decomposition:
- Shared package (mcu_pkg): INSTR_W, opcode constants (NOP/MOV/JMP/SLP/ADD/SUB/MUL/NOT encodings), NOP_WORD, state enum encodings IDLE=2'd0, RUN=2'd1, SLEEP=2'd2.
- One natural sub-module: slp_timer (load, tick, decrement, done flag). The memory stays inline.

Test Plan:
- Load 3 lines (A,B,C), prog_len=3, start → instr sequence A,B,C,A,B over 5 cycles; pc 0,1,2,0,1; instr_valid=1 throughout.
- At pc=1 assert is_jmp, jmp_target=0 → next pc=0. Repeat with jmp_target=5 (len 3) → pc=0.
- At pc=0 assert is_slp, slp_count=3; tick every 4th cycle → sleeping=1 and instr=NOP_WORD until the 3rd tick; pc=1 issued the cycle after.
- is_slp with slp_count=0 → no SLEEP, pc advances 0→1. is_jmp+is_slp together, target=2 → pc=2, sleeping stays 0.
- Assert reset during SLEEP (slp_cnt=2) → next cycle state IDLE, pc=0, instr_valid=0. Restart → first instr equals the previously loaded line 0.
- load_en during RUN writing line 0 → memory unchanged. prog_len=0 with start → stays IDLE, running=0.
